uart_rx: RTL and testbench

Serial UART receiver: recovers 8N1 frames from the asynchronous `i_RX` line and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart to the board's baud-rate-divided transmit path. It runs directly on the 50 MHz system clock, deriving bit timing from an internal counter instead of a divided clock. It sits between the board RX pin and the byte-consuming logic (display / command decoder).

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: serial line in, recovered byte and status out.
// master = the receiver itself, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       i_RX;
  logic [7:0] o_DATA;
  logic       o_VALID;
  logic       o_FRAME_ERR;
  logic       o_BUSY;

  modport master (
    input  i_RX,
    output o_DATA,
    output o_VALID,
    output o_FRAME_ERR,
    output o_BUSY
  );

  modport slave (
    output i_RX,
    input  o_DATA,
    input  o_VALID,
    input  o_FRAME_ERR,
    input  o_BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver running on the system clock; a bit-period counter places
// every sample at mid-bit, and each good byte is announced with a one-cycle strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      i_CLK_50M,
  input  logic      RST,
  uart_rx_if.master bus
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // Two metastability stages plus one input stage, so START is entered
  // three edges after the line is first sampled low.
  logic [2:0]  sync_reg;
  logic        rx_s;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  sh_reg, sh_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        ferr_reg, ferr_next;

  assign rx_s = sync_reg[2];

  always_ff @(posedge i_CLK_50M) begin
    if (RST) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], bus.i_RX};
    end
  end

  always_ff @(posedge i_CLK_50M) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      idx_reg   <= 3'd0;
      sh_reg    <= 8'd0;
      data_reg  <= 8'd0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = 16'd0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = 16'd0;
          // A line that is high again at the start-bit midpoint was only a glitch.
          if (!rx_s) begin
            state_next = DATA;
            idx_next   = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = 16'd0;
          sh_next  = {rx_s, sh_reg[7:1]};
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = 16'd0;
          // Returning to IDLE at mid-stop-bit leaves room for a back-to-back start bit.
          if (rx_s) begin
            data_next  = sh_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      WAIT_HIGH: begin
        cnt_next = 16'd0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

  assign bus.o_DATA      = data_reg;
  assign bus.o_VALID     = valid_reg;
  assign bus.o_FRAME_ERR = ferr_reg;
  assign bus.o_BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (16, 100, 1302 clocks per bit) driven with
// table, random and hand-written frames and compared against a waveform-sampling model.
module tb_uart_rx;
  localparam int CPB_A = 16;
  localparam int CPB_B = 100;
  localparam int CPB_C = 1302;

  typedef struct {
    int         t;
    bit         ferr;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  uart_rx_if if_a ();
  uart_rx_if if_b ();
  uart_rx_if if_c ();

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (.i_CLK_50M(clk), .RST(rst_a), .bus(if_a.master));
  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (.i_CLK_50M(clk), .RST(rst_b), .bus(if_b.master));
  uart_rx #(.CLKS_PER_BIT(CPB_C)) dut_c (.i_CLK_50M(clk), .RST(rst_c), .bus(if_c.master));

  logic [2:0] v, fe, bz;
  logic [7:0] dq [3];
  assign v  = {if_c.o_VALID, if_b.o_VALID, if_a.o_VALID};
  assign fe = {if_c.o_FRAME_ERR, if_b.o_FRAME_ERR, if_a.o_FRAME_ERR};
  assign bz = {if_c.o_BUSY, if_b.o_BUSY, if_a.o_BUSY};
  assign dq[0] = if_a.o_DATA;
  assign dq[1] = if_b.o_DATA;
  assign dq[2] = if_c.o_DATA;

  ev_t        act_q [3][$];
  ev_t        exp_q [3][$];
  int         rise_t [3];
  int         fall_t [3];
  logic [7:0] last_good [3];
  logic [2:0] v_prev  = 3'b000;
  logic [2:0] fe_prev = 3'b000;
  logic [2:0] bz_prev = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge; cyc then names the rising edge just passed.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (v[k] || fe[k]) begin
        check($sformatf("pulse_excl%0d", k), {31'd0, v[k] & fe[k]}, 32'd0);
        check($sformatf("pulse_len%0d", k), {31'd0, v_prev[k] | fe_prev[k]}, 32'd0);
        act_q[k].push_back('{cyc, fe[k], dq[k]});
      end
      if (bz[k] && !bz_prev[k]) rise_t[k] = cyc;
      if (!bz[k] && bz_prev[k]) fall_t[k] = cyc;
    end
    v_prev  = v;
    fe_prev = fe;
    bz_prev = bz;
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int k, input logic val);
    case (k)
      0:       if_a.i_RX = val;
      1:       if_b.i_RX = val;
      default: if_c.i_RX = val;
    endcase
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, each p cycles long.
  // e is the first edge that samples the start bit low.
  task automatic send_frame(input int k, input logic [7:0] d, input bit stop, input int p,
                            output int e);
    logic [9:0] wave;
    wave = {stop, d, 1'b0};
    e = cyc + 1;
    for (int b = 0; b < 10; b++) begin
      set_rx(k, wave[b]);
      tick(p);
    end
  endtask

  // Reference: what a mid-bit sampler with period c sees on a waveform of period p.
  // Returns {stop level seen, byte seen}.
  function automatic logic [8:0] model_rx(input logic [7:0] d, input bit stop, input int c,
                                          input int p);
    logic [9:0] wave;
    logic [8:0] r;
    int t, b;
    wave = {stop, d, 1'b0};
    for (int k = 0; k < 9; k++) begin
      t = c / 2 + (k + 1) * c;
      b = t / p;
      r[k] = (b <= 9) ? wave[b] : 1'b1;
    end
    return r;
  endfunction

  function automatic int event_time(input int e, input int c);
    return e + 3 + c / 2 + 9 * c;
  endfunction

  task automatic expect_frame(input int k, input int e, input logic [7:0] d, input bit stop,
                              input int c, input int p);
    logic [8:0] s;
    s = model_rx(d, stop, c, p);
    if (s[8]) begin
      last_good[k] = s[7:0];
      exp_q[k].push_back('{event_time(e, c), 1'b0, s[7:0]});
    end else begin
      exp_q[k].push_back('{event_time(e, c), 1'b1, last_good[k]});
    end
  endtask

  task automatic compare_q(input int k, input string tag);
    ev_t ee, aa;
    check({tag, "_events"}, act_q[k].size(), exp_q[k].size());
    while (exp_q[k].size() > 0 && act_q[k].size() > 0) begin
      ee = exp_q[k].pop_front();
      aa = act_q[k].pop_front();
      check({tag, "_time"}, aa.t, ee.t);
      check({tag, "_kind"}, {31'd0, aa.ferr}, {31'd0, ee.ferr});
      check({tag, "_data"}, {24'd0, aa.d}, {24'd0, ee.d});
    end
    act_q[k].delete();
    exp_q[k].delete();
  endtask

  task automatic run_frame(input int k, input logic [7:0] d, input bit stop, input int c,
                           input int p, input int gap, input string tag);
    int e, r, tev;
    logic [8:0] s;
    s = model_rx(d, stop, c, p);
    send_frame(k, d, stop, p, e);
    set_rx(k, 1'b1);
    r = cyc + 1;
    expect_frame(k, e, d, stop, c, p);
    tev = event_time(e, c);
    wait_until(tev + 2);
    tick(gap);
    compare_q(k, tag);
    check({tag, "_busy_rise"}, rise_t[k], e + 3);
    check({tag, "_busy_fall"}, fall_t[k], s[8] ? tev : r + 3);
    check({tag, "_hold"}, {24'd0, dq[k]}, {24'd0, last_good[k]});
    $display("frame %s dut=%0d data=%02h stop=%0d period=%0d out=%02h", tag, k, d, stop, p, dq[k]);
  endtask

  initial begin
    vec_t       vecs [10];
    int         e, r;
    logic [8:0] s;
    logic [7:0] lg;
    logic [9:0] w;

    for (int k = 0; k < 3; k++) begin
      set_rx(k, 1'b1);
      last_good[k] = 8'd0;
      rise_t[k] = 0;
      fall_t[k] = 0;
    end
    tick(4);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_data%0d", k), {24'd0, dq[k]}, 32'd0);
      check($sformatf("reset_valid%0d", k), {31'd0, v[k]}, 32'd0);
      check($sformatf("reset_ferr%0d", k), {31'd0, fe[k]}, 32'd0);
      check($sformatf("reset_busy%0d", k), {31'd0, bz[k]}, 32'd0);
      $display("reset dut=%0d data=%02h valid=%0d ferr=%0d busy=%0d", k, dq[k], v[k], fe[k], bz[k]);
    end

    // Table of frames for the 16-clock instance.
    vecs[0] = '{8'h55, 1'b1, 6, 1'b0, 8'h00};
    vecs[1] = '{8'h00, 1'b1, 5, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 9, 1'b0, 8'h00};
    vecs[3] = '{8'h01, 1'b1, 5, 1'b0, 8'h00};
    vecs[4] = '{8'h80, 1'b1, 7, 1'b0, 8'h00};
    vecs[5] = '{8'hE7, 1'b0, 12, 1'b0, 8'h00};
    vecs[6] = '{8'($urandom), 1'b1, 5, 1'b0, 8'h00};
    vecs[7] = '{8'($urandom), 1'b0, 8, 1'b0, 8'h00};
    vecs[8] = '{8'($urandom), 1'b1, 6, 1'b0, 8'h00};
    vecs[9] = '{8'($urandom), 1'b1, 5, 1'b0, 8'h00};
    lg = last_good[0];
    for (int i = 0; i < 10; i++) begin
      s = model_rx(vecs[i].data, vecs[i].stop, CPB_A, CPB_A);
      vecs[i].exp_valid = s[8];
      if (s[8]) lg = s[7:0];
      vecs[i].exp_data = lg;
    end
    for (int i = 0; i < 10; i++) begin
      run_frame(0, vecs[i].data, vecs[i].stop, CPB_A, CPB_A, vecs[i].gap, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_out", i), {24'd0, dq[0]}, {24'd0, vecs[i].exp_data});
    end

    // Low glitch shorter than half a bit: busy blips, no strobe.
    set_rx(0, 1'b0);
    e = cyc + 1;
    tick(5);
    set_rx(0, 1'b1);
    tick(40);
    compare_q(0, "glitch");
    check("glitch_busy_rise", rise_t[0], e + 3);
    check("glitch_busy_fall", fall_t[0], e + 3 + CPB_A / 2);
    $display("glitch dut=0 low=5 busy_rise=%0d busy_fall=%0d", rise_t[0], fall_t[0]);

    // Stop bit low followed by a long break, then a clean frame.
    run_frame(0, 8'h5A, 1'b1, CPB_A, CPB_A, 5, "pre_break");
    send_frame(0, 8'h3C, 1'b0, CPB_A, e);
    expect_frame(0, e, 8'h3C, 1'b0, CPB_A, CPB_A);
    tick(40 * CPB_A);
    check("break_busy", {31'd0, bz[0]}, 32'd1);
    set_rx(0, 1'b1);
    r = cyc + 1;
    tick(10);
    compare_q(0, "break");
    check("break_busy_fall", fall_t[0], r + 3);
    check("break_hold", {24'd0, dq[0]}, {24'd0, last_good[0]});
    $display("frame break dut=0 data=3c stop=0 out=%02h", dq[0]);
    run_frame(0, 8'h81, 1'b1, CPB_A, CPB_A, 5, "after_break");

    // Reset pulse in the middle of bit 4.
    w = {1'b1, 8'hB5, 1'b0};
    for (int b = 0; b < 5; b++) begin
      set_rx(0, w[b]);
      tick(CPB_A);
    end
    set_rx(0, w[5]);
    tick(CPB_A / 2);
    rst_a = 1'b1;
    tick(1);
    check("midrst_data", {24'd0, dq[0]}, 32'd0);
    check("midrst_valid", {31'd0, v[0]}, 32'd0);
    check("midrst_ferr", {31'd0, fe[0]}, 32'd0);
    check("midrst_busy", {31'd0, bz[0]}, 32'd0);
    rst_a = 1'b0;
    set_rx(0, 1'b1);
    last_good[0] = 8'd0;
    tick(20 * CPB_A);
    compare_q(0, "midrst");
    $display("reset mid-frame dut=0 data=%02h busy=%0d", dq[0], bz[0]);
    run_frame(0, 8'h7E, 1'b1, CPB_A, CPB_A, 5, "after_rst");

    // Baud skew and random frames on the 100-clock instance.
    run_frame(1, 8'hC9, 1'b1, CPB_B, 103, 10, "skew_long");
    run_frame(1, 8'hC9, 1'b1, CPB_B, 97, 10, "skew_short");
    for (int i = 0; i < 6; i++) begin
      run_frame(1, 8'($urandom), ($urandom_range(0, 4) != 0), CPB_B, $urandom_range(97, 103),
                10, $sformatf("rnd%0d", i));
    end

    // Three frames with no idle gap at the default rate.
    send_frame(2, 8'hA3, 1'b1, CPB_C, e);
    expect_frame(2, e, 8'hA3, 1'b1, CPB_C, CPB_C);
    send_frame(2, 8'h00, 1'b1, CPB_C, e);
    expect_frame(2, e, 8'h00, 1'b1, CPB_C, CPB_C);
    send_frame(2, 8'hFF, 1'b1, CPB_C, e);
    expect_frame(2, e, 8'hFF, 1'b1, CPB_C, CPB_C);
    wait_until(event_time(e, CPB_C) + 2);
    tick(5);
    compare_q(2, "b2b");
    check("b2b_last", {24'd0, dq[2]}, 32'h000000FF);
    $display("frame b2b dut=2 data=a3,00,ff out=%02h", dq[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
